data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated MEM-stage data memory (two-word reads, 32/64-bit stores); byte stores enabled by DATA_MEM_BYTE_STORE_EN
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic        Store_Byte,
    input  logic [31:0] Adrs,
    input  logic [31:0] Wr_data,
    input  logic [63:0] Wr_data64,
    output logic [31:0] Rd_data,
    output logic [31:0] Rd_nextdata,
    output logic        Resp_valid,
    output logic        Addr_err,
    output logic        Mem_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, BEAT2, RESP} state_t;
    typedef enum logic [2:0] {CMD_NONE, CMD_RD, CMD_WR, CMD_WR64, CMD_BYTE} cmd_t;

    state_t        state, state_next;
    cmd_t          cmd_in, cmd_q;
    logic          mis_in, accept, done, unused_ok;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q, idx_nx;
    logic [1:0]    lane_q;
    logic [31:0]   wr_q;
    logic [63:0]   wr64_q;
    logic [31:0]   mem [DEPTH];

    assign idx_nx = idx_q + AW'(1);

`ifdef DATA_MEM_BYTE_STORE_EN
    assign unused_ok = ^Adrs[31:AW+2];
`else
    assign unused_ok = ^{Adrs[31:AW+2], Store_Byte, lane_q};
`endif

    // decode the incoming command by priority and flag misalignment
    always_comb begin
        cmd_in = MemWrite64 ? CMD_WR64 : MemWrite ? CMD_WR : MemRead ? CMD_RD : CMD_NONE;
`ifdef DATA_MEM_BYTE_STORE_EN
        cmd_in = (cmd_in == CMD_WR && Store_Byte) ? CMD_BYTE : cmd_in;
`endif
        mis_in = (cmd_in == CMD_WR64) ? |Adrs[2:0] :
                 (cmd_in == CMD_WR || cmd_in == CMD_RD) ? |Adrs[1:0] : 1'b0;
    end

    // next-state and handshake outputs
    always_comb begin
        state_next = state;
        accept     = Req_valid && state == IDLE;
        done       = cnt == LAST;
        case (state)
            IDLE:    state_next = !accept ? IDLE : (mis_in || cmd_in == CMD_NONE) ? RESP : WAIT;
            WAIT:    state_next = !done ? WAIT : (cmd_q == CMD_WR64) ? BEAT2 : RESP;
            BEAT2:   state_next = RESP;
            default: state_next = IDLE;
        endcase
        Req_ready  = state == IDLE;
        Resp_valid = state == RESP;
        Mem_stall  = accept || state == WAIT || state == BEAT2;
    end

    // state register and wait-state counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= (state == WAIT && !done) ? cnt + 4'd1 : 4'd0;
        end
    end

    // capture the request at accept
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            cmd_q  <= cmd_in;
            idx_q  <= Adrs[AW+1:2];
            lane_q <= Adrs[1:0];
            wr_q   <= Wr_data;
            wr64_q <= Wr_data64;
        end
    end

    // response registers: misaligned/no-op results at accept, read data at end of WAIT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Rd_data     <= 32'd0;
            Rd_nextdata <= 32'd0;
            Addr_err    <= 1'b0;
        end else if (accept) begin
            if (mis_in) {Rd_data, Rd_nextdata, Addr_err} <= {64'd0, 1'b1};
            else if (cmd_in == CMD_NONE) Addr_err <= 1'b0;
        end else if (state == WAIT && done) begin
            Addr_err <= 1'b0;
            if (cmd_q == CMD_RD) begin
                Rd_data     <= mem[idx_q];
                Rd_nextdata <= mem[idx_nx];
            end
        end
    end

    // memory array: never cleared, writes suppressed while Reset is high
    always_ff @(posedge Clk) begin
        if (!Reset && state == WAIT && done) begin
            if (cmd_q == CMD_WR64) mem[idx_q] <= wr64_q[63:32];
            else if (cmd_q == CMD_WR) mem[idx_q] <= wr_q;
`ifdef DATA_MEM_BYTE_STORE_EN
            else if (cmd_q == CMD_BYTE) mem[idx_q][{lane_q, 3'b000} +: 8] <= wr_q[7:0];
`endif
        end
        if (!Reset && state == BEAT2) mem[idx_nx] <= wr64_q[31:0];
    end
endmodule
